mskand_hpc2_sched: RTL and testbench

- Valid/ready sequencer around the cross-term HPC2 masked AND gadget, MSKand_hpc2_cross.
- Handles the gadget's skewed input timing: inb and rnd go in at cycle t, ina at t+1.
- Draws one fresh randomness word per operation from an upstream PRNG handshake.
- Buffers results in an output share FIFO, so downstream backpressure never stalls the free-running gadget pipeline.
- Used as the nonlinear-op front end for small masked datapaths, e.g. the S-box AND layer.

---
 rtl/mskand_hpc2_sched_pkg.sv | 14 +
 rtl/MSKand_hpc2_cross.sv | 63 ++++++
 rtl/mskand_share_fifo.sv | 66 ++++++
 rtl/mskand_share_fifo_chk.sv | 16 +
 rtl/mskand_hpc2_sched.sv | 83 ++++++++
 tb/tb_mskand_hpc2_sched.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/mskand_hpc2_sched_pkg.sv
// Shared HPC2 helpers: randomness width per gadget and the mapping from a
// share pair (i<j) to its randomness bit.
package mskand_hpc2_sched_pkg;

  function automatic int hpc2rnd(input int d);
    return (d * (d - 1)) / 2;
  endfunction

  // Row-major index of pair (i,j), i<j, in the upper triangle.
  function automatic int pair_idx(input int i, input int j, input int d);
    return (i * d) - ((i * (i + 1)) / 2) + (j - i - 1);
  endfunction

endpackage

// File: rtl/MSKand_hpc2_cross.sv
// HPC2 masked AND, cross-term form: inb/rnd enter at cycle t, ina at t+1,
// out_c valid at t+2. have_inner=1 adds the a_i&b_i terms.
module MSKand_hpc2_cross
  import mskand_hpc2_sched_pkg::*;
#(
  parameter int d          = 2,
  parameter int have_inner = 0
) (
  input  logic                    clk,
  input  logic [d-1:0]            ina,
  input  logic [d-1:0]            inb,
  input  logic [hpc2rnd(d)-1:0]   rnd,
  output logic [d-1:0]            out_c
);

  logic [d-1:0][d-1:0] r_d, r_q, br_d, br_q, nr_d, nr_q, ar_d, ar_q;
  logic [d-1:0]        b_d, b_q, ab_d, ab_q;

  // Stage 1 masks b_j with r_ij; stage 2 multiplies by a_i once the b side is registered.
  always_comb begin
    r_d  = '0;
    br_d = '0;
    nr_d = '0;
    ar_d = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i != j) begin
          r_d[i][j]  = rnd[pair_idx((i < j) ? i : j, (i < j) ? j : i, d)];
          br_d[i][j] = inb[j] ^ rnd[pair_idx((i < j) ? i : j, (i < j) ? j : i, d)];
          nr_d[i][j] = ~ina[i] & r_q[i][j];
          ar_d[i][j] = ina[i] & br_q[i][j];
        end else begin
          r_d[i][j]  = 1'b0;
          br_d[i][j] = 1'b0;
          nr_d[i][j] = 1'b0;
          ar_d[i][j] = 1'b0;
        end
      end
    end
    b_d  = inb;
    ab_d = (have_inner != 0) ? (ina & b_q) : '0;
  end

  always_ff @(posedge clk) begin
    r_q  <= r_d;
    br_q <= br_d;
    nr_q <= nr_d;
    ar_q <= ar_d;
    b_q  <= b_d;
    ab_q <= ab_d;
  end

  // Diagonal terms are held at zero, so every row can be folded unconditionally.
  always_comb begin
    out_c = ab_q;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        out_c[i] = out_c[i] ^ ar_q[i][j] ^ nr_q[i][j];
      end
    end
  end

endmodule

// File: rtl/mskand_share_fifo.sv
// Register-array share FIFO; each share bit is its own flop and the muxes
// are steered only by the pointers. Reset clears pointers and count only.
module mskand_share_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem_d, mem_q;
  logic [PW-1:0]           wr_d, wr_q, rd_d, rd_q;
  logic [CW-1:0]           cnt_d, cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    if (pop) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_q];
  assign count    = cnt_q;

  mskand_share_fifo_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .count (cnt_q)
  );

endmodule

// File: rtl/mskand_share_fifo_chk.sv
// Simulation checker for the share FIFO: a push must never meet a full FIFO.
module mskand_share_fifo_chk #(
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic [CW-1:0] count
);

  a_no_full_push: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count != CW'(DEPTH)))
    else $error("share fifo: push while full");

endmodule

// File: rtl/mskand_hpc2_sched.sv
// Valid/ready sequencer around MSKand_hpc2_cross: skews ina by one cycle,
// pairs each op with one randomness word and buffers results in a share FIFO.
module mskand_hpc2_sched
  import mskand_hpc2_sched_pkg::*;
#(
  parameter int d          = 2,
  parameter int have_inner = 0,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [d-1:0]          in_a,
  input  logic [d-1:0]          in_b,
  input  logic                  rnd_in_valid,
  output logic                  rnd_in_ready,
  input  logic [hpc2rnd(d)-1:0] rnd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [d-1:0]          out_c
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [OW-1:0]         occ_d, occ_q, fifo_cnt_s;
  logic [1:0]            vpipe_d, vpipe_q;
  logic [d-1:0]          a_d, a_q, inb_s, gad_c_s;
  logic [hpc2rnd(d)-1:0] rnd_s;
  logic                  en_d, en_q, space_s, accept_s, pop_s;

  // en_q keeps both readies low for the first cycle after reset as well.
  always_comb begin
    en_d         = 1'b1;
    space_s      = en_q & (occ_q < OW'(DEPTH));
    in_ready     = rnd_in_valid & space_s;
    rnd_in_ready = in_valid & space_s;
    accept_s     = in_valid & rnd_in_valid & space_s;
    pop_s        = out_valid & out_ready;
    occ_d        = occ_q + OW'(accept_s) - OW'(pop_s);
    vpipe_d      = {vpipe_q[0], accept_s};
    a_d          = accept_s ? in_a : '0;
    inb_s        = accept_s ? in_b : '0;
    rnd_s        = accept_s ? rnd_in : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= '0;
      vpipe_q <= '0;
      en_q    <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      vpipe_q <= vpipe_d;
      en_q    <= en_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

  MSKand_hpc2_cross #(.d(d), .have_inner(have_inner)) u_gadget (
    .clk   (clk),
    .ina   (a_q),
    .inb   (inb_s),
    .rnd   (rnd_s),
    .out_c (gad_c_s)
  );

  mskand_share_fifo #(.W(d), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vpipe_q[1]),
    .push_data (gad_c_s),
    .pop       (pop_s),
    .pop_data  (out_c),
    .count     (fifo_cnt_s)
  );

  assign out_valid = (fifo_cnt_s != '0);

endmodule

// File: tb/tb_mskand_hpc2_sched.sv
// Directed bench for mskand_hpc2_sched: a d=2 cross-term instance and a d=3
// instance with inner terms, each checked against a queue of expected XORs.
module tb_mskand_hpc2_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid2 = 1'b0, in_ready2, rnd_valid2 = 1'b0, rnd_ready2;
  logic       out_valid2, out_ready2 = 1'b0;
  logic [1:0] in_a2 = '0, in_b2 = '0, out_c2;
  logic [0:0] rnd2 = '0;

  logic       in_valid3 = 1'b0, in_ready3, rnd_valid3 = 1'b0, rnd_ready3;
  logic       out_valid3, out_ready3 = 1'b0;
  logic [2:0] in_a3 = '0, in_b3 = '0, out_c3, rnd3 = '0;

  int checks = 0;
  int failures = 0;
  logic q2[$];
  logic q3[$];

  mskand_hpc2_sched #(.d(2), .have_inner(0), .DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .rnd_in_valid(rnd_valid2), .rnd_in_ready(rnd_ready2),
    .rnd_in(rnd2), .out_valid(out_valid2), .out_ready(out_ready2), .out_c(out_c2));

  mskand_hpc2_sched #(.d(3), .have_inner(1), .DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a3), .in_b(in_b3), .rnd_in_valid(rnd_valid3), .rnd_in_ready(rnd_ready3),
    .rnd_in(rnd3), .out_valid(out_valid3), .out_ready(out_ready3), .out_c(out_c3));

  // XOR of the shares of the gadget result: sum of a_i&b_j over i!=j, plus i==j when inner.
  function automatic logic model_and(input logic [2:0] a, input logic [2:0] b,
                                     input int n, input bit inner);
    logic r;
    r = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (i != j || inner) r = r ^ (a[i] & b[j]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push at accept, pop and compare at output handshake, flush on reset.
  always @(negedge clk) begin
    if (in_valid2 === 1'b1 && in_ready2 === 1'b1)
      q2.push_back(model_and({1'b0, in_a2}, {1'b0, in_b2}, 2, 1'b0));
    if (out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
      chk("d2_pop_expected", (q2.size() != 0), 1);
      if (q2.size() != 0) chk("d2_and", ^out_c2, q2.pop_front());
    end
    if (in_valid3 === 1'b1 && in_ready3 === 1'b1)
      q3.push_back(model_and(in_a3, in_b3, 3, 1'b1));
    if (out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
      chk("d3_pop_expected", (q3.size() != 0), 1);
      if (q3.size() != 0) chk("d3_and", ^out_c3, q3.pop_front());
    end
    if (rst_n === 1'b0) begin
      q2.delete();
      q3.delete();
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain2();
    int n = 0;
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    while ((q2.size() != 0 || out_valid2) && n < 50) begin
      nxt();
      n++;
    end
    chk("d2_drain", q2.size(), 0);
  endtask

  task automatic single_op(input string tag);
    in_valid2 = 1'b1; in_a2 = 2'b10; in_b2 = 2'b01; rnd2 = 1'b1;
    rnd_valid2 = 1'b1; out_ready2 = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready2, 1);
    nxt();
    in_valid2 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_latency"}, out_valid2, (k == 3));
      if (k == 3) chk({tag, "_xor"}, ^out_c2, 1);
    end
    @(negedge clk);
    chk({tag, "_occ_after"}, u2.occ_q, 0);
    chk({tag, "_ov_after"}, out_valid2, 0);
    nxt();
  endtask

  initial begin
    int acc;
    int combo;
    int cyc;
    // Reset: readies and out_valid held low even with both valids up.
    in_valid2 = 1'b1; rnd_valid2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready2, 0);
    chk("rst_rnd_ready", rnd_ready2, 0);
    chk("rst_out_valid", out_valid2, 0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready2, 0);
    chk("post_rst_out_valid", out_valid2, 0);
    nxt();
    in_valid2 = 1'b0;
    nxt();

    single_op("single");

    // Back-to-back ops, output stream must be 8 contiguous cycles starting +3.
    out_ready2 = 1'b1; rnd_valid2 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        combo = (j * 5 + 3) % 16;
        in_valid2 = 1'b1; in_a2 = combo[3:2]; in_b2 = combo[1:0]; rnd2 = 1'($urandom);
      end else begin
        in_valid2 = 1'b0;
      end
      @(negedge clk);
      if (j < 8) chk("b2b_in_ready", in_ready2, 1);
      chk("b2b_out_valid", out_valid2, (j >= 3 && j < 11));
      nxt();
    end
    drain2();

    // Backpressure: exactly DEPTH accepts, then in order release.
    out_ready2 = 1'b0; in_valid2 = 1'b1; acc = 0;
    for (int j = 0; j < 8; j++) begin
      in_a2 = j[1:0]; in_b2 = 2'(j + 3); rnd2 = 1'($urandom);
      @(negedge clk);
      if (in_ready2) acc++;
      nxt();
    end
    chk("bp_accepts", acc, 4);
    @(negedge clk);
    chk("bp_in_ready", in_ready2, 0);
    chk("bp_out_valid", out_valid2, 1);
    nxt();
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("bp_release_valid", out_valid2, 1);
      nxt();
    end
    @(negedge clk);
    chk("bp_release_done", out_valid2, 0);
    nxt();
    in_valid2 = 1'b1; in_a2 = 2'b11; in_b2 = 2'b11;
    @(negedge clk);
    chk("bp_resume", in_ready2, 1);
    nxt();
    drain2();

    // Randomness starvation.
    in_valid2 = 1'b1; rnd_valid2 = 1'b0; in_a2 = 2'b01; in_b2 = 2'b10;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("starve_in_ready", in_ready2, 0);
      chk("starve_rnd_ready", rnd_ready2, 1);
      chk("starve_occ", u2.occ_q, 0);
      nxt();
    end
    rnd_valid2 = 1'b1;
    @(negedge clk);
    chk("starve_release", in_ready2, 1);
    nxt();
    drain2();

    // Reset with one op buffered and two in flight.
    out_ready2 = 1'b0; rnd_valid2 = 1'b1;
    in_valid2 = 1'b1; in_a2 = 2'b10; in_b2 = 2'b10; nxt();
    in_valid2 = 1'b0; nxt();
    in_valid2 = 1'b1; in_a2 = 2'b01; nxt();
    in_b2 = 2'b11; nxt();
    in_valid2 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_buffered", out_valid2, 1);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid2, 0);
    chk("mid_rst_occ", u2.occ_q, 0);
    out_ready2 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      nxt();
      @(negedge clk);
      chk("mid_rst_no_stale", out_valid2, 0);
    end
    nxt();
    single_op("after_rst");

    // d=3 with inner terms: random traffic, random backpressure and randomness stalls.
    acc = 0; cyc = 0;
    while (acc < 200 && cyc < 4000) begin
      in_valid3 = ($urandom_range(0, 3) != 0);
      rnd_valid3 = ($urandom_range(0, 2) != 0);
      out_ready3 = ($urandom_range(0, 1) != 0);
      in_a3 = 3'($urandom); in_b3 = 3'($urandom); rnd3 = 3'($urandom);
      @(negedge clk);
      if (in_valid3 && in_ready3) acc++;
      nxt();
      cyc++;
    end
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    chk("d3_accepts", acc, 200);
    cyc = 0;
    while ((q3.size() != 0 || out_valid3) && cyc < 50) begin
      nxt();
      cyc++;
    end
    chk("d3_drain", q3.size(), 0);
    chk("d3_occ", u3.occ_q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
